// File: rtl/tile_write_sequencer.sv
// tile_write_sequencer
//
// Producer side of the tile-map framebuffer. Game logic pushes tile-colour
// commands into a small FIFO. This block serialises them onto the
// framebuffer's write port: x, y, 6-bit colour and a rising-edge apply
// strobe (map_toggle). It keeps address and colour stable around every
// strobe, and it can sweep the whole visible grid with a single colour.
//
// Parameters
//   FIFO_DEPTH    command FIFO entries (power of two, 2..32)
//   SETUP_CYCLES  cycles x/y/data are stable with toggle low before the rise
//   HOLD_CYCLES   cycles toggle is held high
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   mult[1:0]          tile scale: 0=1x (56x32), 1=2x (28x16), 3=4x (14x8), 2=invalid
//   cmd_valid/ready    command handshake (ready = FIFO not full, registered-only)
//   cmd_x/y/color      tile column, row, colour
//   clear_req          single-cycle pulse requesting a full-screen sweep
//   clear_color        colour used by the sweep (latched at sweep start)
//   map_x/y/data       framebuffer address and colour
//   map_toggle         apply strobe; framebuffer writes on its rising edge
//   busy               FSM not IDLE, or FIFO non-empty
//   clear_done         one-cycle pulse at the end of a sweep
//   cmd_err            one-cycle pulse when a command is dropped at pop time
//   write_count[15:0]  only with TILE_WRITE_COUNT_EN defined: counts strobe
//                      rising edges (sweep writes included), wraps at 0xFFFF
//
// Optional feature macro: TILE_WRITE_COUNT_EN

module tile_write_sequencer #(
  parameter int FIFO_DEPTH   = 8,
  parameter int SETUP_CYCLES = 2,
  parameter int HOLD_CYCLES  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] mult,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_x,
  input  logic [7:0] cmd_y,
  input  logic [5:0] cmd_color,
  input  logic       clear_req,
  input  logic [5:0] clear_color,
  output logic [7:0] map_x,
  output logic [7:0] map_y,
  output logic [5:0] map_data,
  output logic       map_toggle,
  output logic       busy,
  output logic       clear_done,
  output logic       cmd_err
`ifdef TILE_WRITE_COUNT_EN
  ,
  output logic [15:0] write_count
`endif
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CMAX = (SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYCLES - 1);
  localparam logic [1:0]    MULT_BAD   = 2'd2;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SETUP      = 3'd1,
    STROBE     = 3'd2,
    RELEASE    = 3'd3,
    CLEAR_NEXT = 3'd4
  } state_t;

  // Visible grid for a scale setting; the invalid scale yields an empty grid.
  function automatic logic [7:0] grid_cols(input logic [1:0] m);
    case (m)
      2'd0:    grid_cols = 8'd56;
      2'd1:    grid_cols = 8'd28;
      2'd3:    grid_cols = 8'd14;
      default: grid_cols = 8'd0;
    endcase
  endfunction

  function automatic logic [7:0] grid_rows(input logic [1:0] m);
    case (m)
      2'd0:    grid_rows = 8'd32;
      2'd1:    grid_rows = 8'd16;
      2'd3:    grid_rows = 8'd8;
      default: grid_rows = 8'd0;
    endcase
  endfunction

  // Command FIFO: pointers carry one extra wrap bit so full and empty differ.
  logic [21:0]  mem [FIFO_DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr;
  logic         fifo_empty, fifo_full, push, pop;
  logic [7:0]   head_x, head_y;
  logic [5:0]   head_c;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign cmd_ready  = !fifo_full;
  assign push       = cmd_valid && !fifo_full;
  assign {head_x, head_y, head_c} = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {cmd_x, cmd_y, cmd_color};
  end

  // Control state
  state_t      state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic        clear_pend, pend_n;
  logic        sweeping, sweep_n;
  logic [1:0]  lat_mult, lat_mult_n;
  logic [5:0]  lat_color, lat_color_n;
  logic [7:0]  sx, sy, sx_n, sy_n;
  logic        last_tile, last_n;
  logic [7:0]  ld_x, ld_y;
  logic [5:0]  ld_d;
  logic        tog_n, err_n, done_n;
  logic        decide, sweep_step;
  logic [7:0]  sw_cols, sw_rows;

  assign busy    = (state != IDLE) || !fifo_empty;
  assign sw_cols = grid_cols(lat_mult);
  assign sw_rows = grid_rows(lat_mult);

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    pop         = 1'b0;
    ld_x        = map_x;
    ld_y        = map_y;
    ld_d        = map_data;
    tog_n       = map_toggle;
    err_n       = 1'b0;
    done_n      = 1'b0;
    sweep_n     = sweeping;
    // A request while one is pending or running is simply ignored.
    pend_n      = clear_pend | (clear_req & ~sweeping);
    lat_mult_n  = lat_mult;
    lat_color_n = lat_color;
    sx_n        = sx;
    sy_n        = sy;
    last_n      = last_tile;
    decide      = 1'b0;
    sweep_step  = 1'b0;

    case (state)
      IDLE: decide = 1'b1;
      SETUP: begin
        if (cnt == SETUP_LAST) begin
          state_n = STROBE;
          cnt_n   = '0;
          tog_n   = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      STROBE: begin
        if (cnt == HOLD_LAST) begin
          state_n = RELEASE;
          cnt_n   = '0;
          tog_n   = 1'b0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      RELEASE: begin
        // Mid-sweep the next tile is loaded straight away so the sweep keeps
        // the same write period as back-to-back commands.
        if (sweeping && !last_tile) begin
          sweep_step = 1'b1;
        end else begin
          if (sweeping) begin
            done_n  = 1'b1;
            sweep_n = 1'b0;
          end
          decide = 1'b1;
        end
      end
      CLEAR_NEXT: sweep_step = 1'b1;
      default: state_n = IDLE;
    endcase

    if (decide) begin
      state_n = IDLE;
      if (clear_pend) begin
        pend_n      = 1'b0;
        lat_mult_n  = mult;
        lat_color_n = clear_color;
        if (mult == MULT_BAD) begin
          // Empty grid: the sweep is over as soon as it starts.
          done_n = 1'b1;
        end else begin
          sweep_n = 1'b1;
          sx_n    = 8'd0;
          sy_n    = 8'd0;
          state_n = CLEAR_NEXT;
        end
      end else if (!fifo_empty) begin
        pop = 1'b1;
        if (mult == MULT_BAD || head_x >= grid_cols(mult) || head_y >= grid_rows(mult)) begin
          err_n = 1'b1;
        end else begin
          ld_x    = head_x;
          ld_y    = head_y;
          ld_d    = head_c;
          cnt_n   = '0;
          state_n = SETUP;
        end
      end
    end

    if (sweep_step) begin
      ld_x    = sx;
      ld_y    = sy;
      ld_d    = lat_color;
      last_n  = (sx == sw_cols - 8'd1) && (sy == sw_rows - 8'd1);
      cnt_n   = '0;
      state_n = SETUP;
      if (sx == sw_cols - 8'd1) begin
        sx_n = 8'd0;
        sy_n = sy + 8'd1;
      end else begin
        sx_n = sx + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      map_x      <= 8'd0;
      map_y      <= 8'd0;
      map_data   <= 6'd0;
      map_toggle <= 1'b0;
      cmd_err    <= 1'b0;
      clear_done <= 1'b0;
      clear_pend <= 1'b0;
      sweeping   <= 1'b0;
      lat_mult   <= 2'd0;
      sx         <= 8'd0;
      sy         <= 8'd0;
      last_tile  <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      map_x      <= ld_x;
      map_y      <= ld_y;
      map_data   <= ld_d;
      map_toggle <= tog_n;
      cmd_err    <= err_n;
      clear_done <= done_n;
      clear_pend <= pend_n;
      sweeping   <= sweep_n;
      lat_mult   <= lat_mult_n;
      sx         <= sx_n;
      sy         <= sy_n;
      last_tile  <= last_n;
    end
  end

  always_ff @(posedge clk) begin
    lat_color <= lat_color_n;
  end

`ifdef TILE_WRITE_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_count <= 16'd0;
    end else if (tog_n && !map_toggle) begin
      write_count <= write_count + 16'd1;
    end
  end
`endif

endmodule

// File: doc/tile_write_sequencer.md
Name: tile_write_sequencer

Overview:
- Producer side of the tile-map framebuffer. Game logic (snake/pong) pushes tile-colour commands into this block.
- It serialises them into the framebuffer's write interface: x, y, 6-bit colour and a positive-edge apply strobe.
- It guarantees the address and colour are stable around every strobe edge.
- It also runs a full-screen clear sweep on request.

Parameters:
- FIFO_DEPTH, 8, command FIFO entries (power of two, 2..32).
- SETUP_CYCLES, 2, cycles x/y/data are held stable with toggle low before the rising edge (>=1).
- HOLD_CYCLES, 2, cycles toggle is held high (>=1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- mult  in  2  tile scale: 0=1x, 1=2x, 3=4x, 2=invalid.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  FIFO not full.
- cmd_x  in  8  tile column.
- cmd_y  in  8  tile row.
- cmd_color  in  6  tile colour.
- clear_req  in  1  single-cycle pulse: start clear sweep.
- clear_color  in  6  colour used by the sweep.
- map_x  out  8  framebuffer x.
- map_y  out  8  framebuffer y.
- map_data  out  6  framebuffer colour.
- map_toggle  out  1  apply strobe; the framebuffer writes on its rising edge.
- busy  out  1  FSM not IDLE, or FIFO non-empty.
- clear_done  out  1  one-cycle pulse at sweep end.
- cmd_err  out  1  one-cycle pulse when a command is dropped.

Behaviour:
- Reset (async, rst_n low):
  - All outputs are 0, except cmd_ready, which is 1.
  - FIFO is emptied, FSM goes to IDLE, the sweep counters are cleared and the latched mult is 0.
  - Asserting reset mid-strobe drops map_toggle to 0 immediately.
- Grid size depends on mult: cols = 56/(mult+1), rows = 32/(mult+1). That gives 56x32, 28x16 and 14x8.
- FIFO push: on a clk edge with cmd_valid & cmd_ready. cmd_ready = !full, registered-equivalent with no combinational path from cmd_valid.
- FSM states are IDLE, SETUP, STROBE, RELEASE and CLEAR_NEXT.
- From IDLE:
  - A pending clear takes priority: go to CLEAR_NEXT.
  - Otherwise, with the FIFO non-empty: pop the head, check it, load map_x/map_y/map_data, go to SETUP.
- Command check at pop: cmd_x >= cols, cmd_y >= rows, or mult==2 means the command is discarded, cmd_err pulses, no strobe occurs and the FSM stays in IDLE.
- SETUP: toggle low for SETUP_CYCLES cycles, then STROBE.
- STROBE: toggle high for HOLD_CYCLES cycles, then RELEASE.
- RELEASE: toggle low for 1 cycle, and map_x/y/data stay unchanged. It then takes the same decision as IDLE directly, so back-to-back writes have a period of SETUP_CYCLES+HOLD_CYCLES+1.
- Latency: a push at edge N with an idle FSM gives:
  - outputs loaded at edge N+1;
  - toggle rises at edge N+1+SETUP_CYCLES;
  - toggle falls HOLD_CYCLES later.
- map_x/y/data change only on the edge that enters SETUP, never while toggle is high or in RELEASE.
- Clear:
  - clear_req sets a pending flag. The request is serviced after any in-flight strobe completes.
  - clear_color and mult are latched when the sweep starts.
  - The sweep visits y=0..rows-1 (outer) and x=0..cols-1 (inner), one full strobe sequence per tile.
  - After the last tile's RELEASE, clear_done pulses and the FSM returns to the IDLE decision.
  - If the latched mult is 2, the sweep performs no strobes and clear_done pulses on the cycle after the sweep starts.
  - clear_req while a clear is pending or running is ignored.
  - The FIFO keeps accepting commands during a sweep; queued commands drain after it.
- Changing mult mid-sweep has no effect on the running sweep. A command is checked against mult at pop time.
- FIFO wrap: the read and write pointers carry an extra wrap bit. Full and empty are distinguished by that bit.
- Simultaneous push and pop when full: the push is refused because cmd_ready=0 that cycle.

Optional Feature:
TILE_WRITE_COUNT_EN:
- Defined: adds output write_count[15:0]. It increments by 1 on every map_toggle rising edge, sweep writes included, and wraps at 0xFFFF->0. It resets to 0.
- Undefined: the port and counter are absent, and everything else is identical.

Test Plan:
- mult=0, push (x=3,y=5,color=0x2A) at edge N, default params -> map_x=3, map_y=5, map_data=0x2A from N+1; toggle high at edges N+3..N+4, low at N+5; exactly one rising edge.
- Push 9 commands back-to-back with FIFO_DEPTH=8 while idle -> cmd_ready drops after the FIFO fills. All accepted commands are strobed in order with a 5-cycle period, and no data changes while toggle is high.
- mult=1, push (x=28,y=0) then (x=27,y=15) -> first gives cmd_err and no strobe; second is written normally.
- mult=3, clear_req with clear_color=0x3F -> 112 strobes in y-major, x-minor order, ending at (13,7); clear_done pulses once; busy is low afterwards.
- Clear running at mult=0 while 3 commands are pushed -> all 1792 sweep writes complete first, then the 3 commands in push order; a second clear_req mid-sweep produces no extra sweep.
- rst_n low while toggle is high mid-sweep -> toggle goes to 0 immediately; FIFO empty; busy=0; no clear_done; normal operation after release.
